// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load-side and serial-side handshake bundle for piso_serializer
interface piso_serializer_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] load_data;
  logic load_valid;
  logic load_ready;
  logic ser_out;
  logic ser_valid;
  logic ser_ready;
  logic ser_last;
  logic busy;
  modport master (
    output load_data, load_valid, ser_ready,
    input  load_ready, ser_out, ser_valid, ser_last, busy
  );
  modport slave (
    input  load_data, load_valid, ser_ready,
    output load_ready, ser_out, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: PISO shift register with valid/ready on both sides.
// Define PISO_PARITY_EN to append an even-parity beat after each word.
module piso_serializer #(
  parameter int WIDTH = 4,
  parameter int MSB_FIRST = 0
) (
  input logic clk,
  input logic rst,
  piso_serializer_if.slave bus
);
`ifdef PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0] cnt, cnt_n;
  logic busy, last, load, beat, data_bit;
  assign busy = state == SHIFT;
  assign last = busy && cnt == CW'(NBITS - 1);
  assign load = bus.load_valid && bus.load_ready;
  assign beat = busy && bus.ser_ready;
  assign data_bit = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
  assign bus.busy = busy;
  assign bus.ser_valid = busy;
  assign bus.ser_last = last;
  assign bus.load_ready = !busy || (last && bus.ser_ready);
`ifdef PISO_PARITY_EN
  logic par;
  always_ff @(posedge clk)
    if (rst) par <= 1'b0;
    else if (load) par <= ^bus.load_data;
  // shreg is already drained when the parity beat is presented
  assign bus.ser_out = busy && (cnt == CW'(WIDTH) ? par : data_bit);
`else
  assign bus.ser_out = busy && data_bit;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt <= cnt_n;
    end
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n = cnt;
    if (beat) begin
      shreg_n = (MSB_FIRST != 0) ? shreg << 1 : shreg >> 1;
      cnt_n = cnt + 1'b1;
      state_n = last ? IDLE : SHIFT;
    end
    if (load) begin
      shreg_n = bus.load_data;
      cnt_n = '0;
      state_n = SHIFT;
    end
  end
endmodule
